ps2_kbd_ctrl: RTL and testbench

Scan-code sequencer between the PS/2 byte receiver and the consumer logic (CPU MMIO / display path).
- Consumes raw received bytes and resolves the E0 (extended) and F0 (break) prefix sequences.
- Emits one decoded key event per make/break code into a small FWFT FIFO with valid/ready handshake.
- Maintains a press counter and the currently-held key.

---
 rtl/ps2_kbd_ctrl.sv | 263 ++++++++++++++++++++++++++
 tb/tb_ps2_kbd_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_kbd_ctrl
//  Description : PS/2 scan-code sequencer. Resolves E0 (extended) and F0
//                (break) prefixes from the byte receiver, pushes one decoded
//                key event per make/break code into a first-word-fall-through
//                FIFO, and tracks a press counter plus the currently-held key.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          system clock
//    resetn       synchronous active-low reset
//    rx_valid     one-cycle strobe, rx_data holds a new byte
//    rx_data      received byte (parity/framing checked upstream)
//    evt_valid    FIFO non-empty, head event presented
//    evt_ready    consumer accepts head event
//    evt_code     head event scan code, prefixes stripped
//    evt_ext      head event carried the E0 prefix
//    evt_brk      head event is a release
//    fifo_level   current FIFO occupancy, 0..FIFO_DEPTH
//    press_cnt    number of make events accepted into the FIFO (wraps)
//    held_valid   a key is currently held
//    held_code    {ext, code} of the held key
//    overflow     sticky, an event was dropped on a full FIFO
//    ovf_clr      clears overflow unless a drop happens in the same cycle
//  Build option
//    PS2_TYPEMATIC_FILTER_EN : when defined, autorepeat makes of the held key
//                              are discarded before reaching the FIFO.
// ============================================================================
module ps2_kbd_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          rx_valid,
    input  logic [7:0]                    rx_data,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [7:0]                    evt_code,
    output logic                          evt_ext,
    output logic                          evt_brk,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]              press_cnt,
    output logic                          held_valid,
    output logic [8:0]                    held_code,
    output logic                          overflow,
    input  logic                          ovf_clr
);

    localparam int c_aw = $clog2(FIFO_DEPTH);
    localparam int c_lw = c_aw + 1;

    localparam logic [7:0] c_pfx_ext = 8'hE0;
    localparam logic [7:0] c_pfx_brk = 8'hF0;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic       w_dec_push;
    logic       w_dec_ext;
    logic       w_dec_brk;
    logic       w_err_byte;
    logic       w_ctl_byte;

    // Decoded event registered once before it reaches the FIFO; this stage
    // gives the one-cycle event latency after the final byte.
    logic       r_pend;
    logic       r_pend_ext;
    logic       r_pend_brk;
    logic [7:0] r_pend_code;

    logic [9:0]       r_mem [FIFO_DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_lw-1:0]  r_level;
    logic [CNT_W-1:0] r_press_cnt;
    logic             r_held_valid;
    logic [8:0]       r_held_code;
    logic             r_overflow;

    logic       w_is_repeat;
    logic       w_push;
    logic       w_pop;
    logic       w_full;
    logic       w_accept;
    logic       w_drop;
    logic [9:0] w_head;

    assign w_err_byte = (rx_data == 8'h00) || (rx_data == 8'hFF);
    // Self-test pass, ACK and echo responses: meaningless as key codes when
    // no prefix is pending.
    assign w_ctl_byte = (rx_data == 8'hAA) || (rx_data == 8'hFA) || (rx_data == 8'hEE);

    // ------------------------------------------------------------------------
    // Prefix sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dec_push  = 1'b0;
        w_dec_ext   = 1'b0;
        w_dec_brk   = 1'b0;
        if (rx_valid) begin
            if (w_err_byte) begin
                w_state_nxt = S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (rx_data == c_pfx_ext) begin
                            w_state_nxt = S_EXT;
                        end else if (rx_data == c_pfx_brk) begin
                            w_state_nxt = S_BRK;
                        end else if (!w_ctl_byte) begin
                            w_dec_push = 1'b1;
                        end
                    end
                    S_EXT: begin
                        if (rx_data == c_pfx_brk) begin
                            w_state_nxt = S_EXT_BRK;
                        end else if (rx_data != c_pfx_ext) begin
                            w_dec_push  = 1'b1;
                            w_dec_ext   = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                    end
                    S_BRK: begin
                        w_state_nxt = S_IDLE;
                        if (rx_data != c_pfx_ext && rx_data != c_pfx_brk) begin
                            w_dec_push = 1'b1;
                            w_dec_brk  = 1'b1;
                        end
                    end
                    S_EXT_BRK: begin
                        w_state_nxt = S_IDLE;
                        if (rx_data != c_pfx_ext && rx_data != c_pfx_brk) begin
                            w_dec_push = 1'b1;
                            w_dec_ext  = 1'b1;
                            w_dec_brk  = 1'b1;
                        end
                    end
                    default: begin
                        w_state_nxt = S_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_pend      <= 1'b0;
            r_pend_ext  <= 1'b0;
            r_pend_brk  <= 1'b0;
            r_pend_code <= 8'h00;
        end else begin
            r_pend      <= w_dec_push;
            r_pend_ext  <= w_dec_ext;
            r_pend_brk  <= w_dec_brk;
            r_pend_code <= rx_data;
        end
    end

    // ------------------------------------------------------------------------
    // Autorepeat detection is done against the held state at FIFO-push time so
    // it always sees the effect of every earlier accepted event.
    // ------------------------------------------------------------------------
`ifdef PS2_TYPEMATIC_FILTER_EN
    assign w_is_repeat = r_pend && !r_pend_brk && r_held_valid &&
                         ({r_pend_ext, r_pend_code} == r_held_code);
`else
    assign w_is_repeat = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------------
    assign w_push   = r_pend && !w_is_repeat;
    assign w_pop    = evt_valid && evt_ready;
    assign w_full   = (r_level == c_lw'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot a full FIFO needs.
    assign w_accept = w_push && (!w_full || w_pop);
    assign w_drop   = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= {r_pend_ext, r_pend_brk, r_pend_code};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            r_level <= r_level + c_lw'(w_accept) - c_lw'(w_pop);
        end
    end

    // ------------------------------------------------------------------------
    // Press counter, held key and sticky overflow
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_press_cnt  <= '0;
            r_held_valid <= 1'b0;
            r_held_code  <= 9'h000;
            r_overflow   <= 1'b0;
        end else begin
            if (w_accept && !r_pend_brk) begin
                r_press_cnt  <= r_press_cnt + CNT_W'(1);
                r_held_valid <= 1'b1;
                r_held_code  <= {r_pend_ext, r_pend_code};
            end else if (w_accept && ({r_pend_ext, r_pend_code} == r_held_code)) begin
                r_held_valid <= 1'b0;
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs; head fields are forced to zero while empty so the whole output
    // set is zero out of reset.
    // ------------------------------------------------------------------------
    assign w_head     = r_mem[r_rd_ptr];
    assign evt_valid  = (r_level != '0);
    assign evt_code   = evt_valid ? w_head[7:0] : 8'h00;
    assign evt_brk    = evt_valid && w_head[8];
    assign evt_ext    = evt_valid && w_head[9];
    assign fifo_level = r_level;
    assign press_cnt  = r_press_cnt;
    assign held_valid = r_held_valid;
    assign held_code  = r_held_code;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_kbd_ctrl
//  Description : Directed self-checking bench for ps2_kbd_ctrl with
//                hand-computed expected values.
//  Revision    : 1.1 - checking task and watchdog
// ============================================================================
module tb_ps2_kbd_ctrl;

`ifdef PS2_TYPEMATIC_FILTER_EN
    localparam bit c_filt = 1'b1;
`else
    localparam bit c_filt = 1'b0;
`endif

    localparam int c_timeout_cycles = 20000;

    logic       clk;
    logic       resetn;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_brk;
    logic [3:0] fifo_level;
    logic [7:0] press_cnt;
    logic       held_valid;
    logic [8:0] held_code;
    logic       overflow;
    logic       ovf_clr;

    int  n_cmp = 0;
    int  n_err = 0;
    bit  r_done = 1'b0;

    ps2_kbd_ctrl #(
        .FIFO_DEPTH (8),
        .CNT_W      (8)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_code   (evt_code),
        .evt_ext    (evt_ext),
        .evt_brk    (evt_brk),
        .fifo_level (fifo_level),
        .press_cnt  (press_cnt),
        .held_valid (held_valid),
        .held_code  (held_code),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        repeat (c_timeout_cycles) @(posedge clk);
        if (!r_done) begin
            n_err++;
            $error("FAIL timeout: test did not complete within %0d cycles", c_timeout_cycles);
            $finish;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        resetn   = 1'b0;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    // Byte is sampled at the posedge inside this task; returns on the
    // following negedge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Checks the head event at the current negedge, then pops it.
    task automatic pop_chk(input string tag, input logic [7:0] code,
                           input logic ext, input logic brk);
        chk({tag, ".valid"}, evt_valid, 1'b1);
        chk({tag, ".code"},  evt_code,  code);
        chk({tag, ".ext"},   evt_ext,   ext);
        chk({tag, ".brk"},   evt_brk,   brk);
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    initial begin
        resetn    = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst.evt_valid",  evt_valid,  1'b0);
        chk("rst.evt_code",   evt_code,   8'h00);
        chk("rst.fifo_level", fifo_level, 4'd0);
        chk("rst.press_cnt",  press_cnt,  8'd0);
        chk("rst.held_valid", held_valid, 1'b0);
        chk("rst.held_code",  held_code,  9'h000);
        chk("rst.overflow",   overflow,   1'b0);

        // Single make 1C
        send_byte(8'h1C);
        chk("mk1c.early_valid", evt_valid, 1'b0);
        @(negedge clk);
        chk("mk1c.level",      fifo_level, 4'd1);
        chk("mk1c.press_cnt",  press_cnt,  8'd1);
        chk("mk1c.held_valid", held_valid, 1'b1);
        chk("mk1c.held_code",  held_code,  9'h01C);
        pop_chk("mk1c", 8'h1C, 1'b0, 1'b0);
        chk("mk1c.empty", evt_valid, 1'b0);

        // Extended make and break: E0 75, E0 F0 75
        send_byte(8'hE0);
        send_byte(8'h75);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        @(negedge clk);
        chk("ext.level",      fifo_level, 4'd2);
        chk("ext.press_cnt",  press_cnt,  8'd2);
        chk("ext.held_valid", held_valid, 1'b0);
        chk("ext.held_code",  held_code,  9'h175);
        pop_chk("ext.mk", 8'h75, 1'b1, 1'b0);
        pop_chk("ext.bk", 8'h75, 1'b1, 1'b1);
        chk("ext.empty", fifo_level, 4'd0);

        // Overflow: 9 makes 15..1D with consumer stalled
        do_reset();
        for (int i = 0; i < 9; i++) begin
            send_byte(8'h15 + 8'(i));
        end
        @(negedge clk);
        chk("ovf.level",     fifo_level, 4'd8);
        chk("ovf.overflow",  overflow,   1'b1);
        chk("ovf.press_cnt", press_cnt,  8'd8);
        chk("ovf.held_code", held_code,  9'h01C);
        chk("ovf.head",      evt_code,   8'h15);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        @(negedge clk);
        chk("ovf.cleared", overflow, 1'b0);

        // Full FIFO, pop and push in the same cycle
        rx_valid = 1'b1;
        rx_data  = 8'h1E;
        @(negedge clk);
        rx_valid  = 1'b0;
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        chk("fullpp.level",     fifo_level, 4'd8);
        chk("fullpp.overflow",  overflow,   1'b0);
        chk("fullpp.press_cnt", press_cnt,  8'd9);
        for (int i = 0; i < 7; i++) begin
            pop_chk("drain", 8'h16 + 8'(i), 1'b0, 1'b0);
        end
        pop_chk("drain.tail", 8'h1E, 1'b0, 1'b0);
        chk("drain.empty", fifo_level, 4'd0);

        // Reset in the middle of a break sequence
        do_reset();
        send_byte(8'hF0);
        do_reset();
        send_byte(8'h1C);
        @(negedge clk);
        chk("rstmid.level", fifo_level, 4'd1);
        pop_chk("rstmid", 8'h1C, 1'b0, 1'b0);
        chk("rstmid.empty", fifo_level, 4'd0);

        // Autorepeat: 1C 1C 1C F0 1C
        do_reset();
        send_byte(8'h1C);
        send_byte(8'h1C);
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h1C);
        @(negedge clk);
        chk("rep.level",      fifo_level, (c_filt ? 4'd2 : 4'd4));
        chk("rep.press_cnt",  press_cnt,  (c_filt ? 8'd1 : 8'd3));
        chk("rep.held_valid", held_valid, 1'b0);
        pop_chk("rep.mk0", 8'h1C, 1'b0, 1'b0);
        if (!c_filt) begin
            pop_chk("rep.mk1", 8'h1C, 1'b0, 1'b0);
            pop_chk("rep.mk2", 8'h1C, 1'b0, 1'b0);
        end
        pop_chk("rep.bk", 8'h1C, 1'b0, 1'b1);
        chk("rep.empty", fifo_level, 4'd0);

        // Error byte cancels a pending prefix; control bytes ignored in idle
        send_byte(8'hE0);
        send_byte(8'hFF);
        send_byte(8'hAA);
        send_byte(8'h2A);
        @(negedge clk);
        chk("err.level", fifo_level, 4'd1);
        pop_chk("err", 8'h2A, 1'b0, 1'b0);
        chk("err.empty", fifo_level, 4'd0);

        r_done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
